// File: rtl/cpu_pkg.sv
// Shared FSM state encoding and wake-cause codes for the CPU sleep controller,
// the CPU core and the bench.
package cpu_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_SLEEP  = 2'd2,
    ST_RESUME = 2'd3
  } state_t;

  localparam logic [1:0] WAKE_NONE  = 2'b00;
  localparam logic [1:0] WAKE_PIN   = 2'b01;
  localparam logic [1:0] WAKE_TIMER = 2'b10;

endpackage

// File: rtl/cpu_sleep_ctrl_wake_sync.sv
// wake_sync: SYNC_STAGES-deep reset-to-0 synchronizer for the asynchronous wakeup pin.
module wake_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_async,
  output logic o_sync
);

  logic [SYNC_STAGES-1:0] r_sync;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_sync <= '0;
    else       r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
  end

  assign o_sync = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/cpu_sleep_ctrl.sv
// CPU sleep/wake sequencer: RUN -> DRAIN -> SLEEP -> RESUME -> RUN, gating cpu_en.
// Optional wake timer and timer_val port enabled by CPU_SLEEP_WAKE_TIMER_EN.
module cpu_sleep_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = 2,
`ifdef CPU_SLEEP_WAKE_TIMER_EN
  parameter int unsigned TIMER_W       = 8,
`endif
  parameter int unsigned RESUME_CYCLES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sleep_req,
  input  logic               wakeup,
`ifdef CPU_SLEEP_WAKE_TIMER_EN
  input  logic [TIMER_W-1:0] timer_val,
`endif
  output logic               cpu_en,
  output logic               sleeping,
  output logic [1:0]         wake_cause,
  output logic               resume_pulse
);

  localparam int unsigned RES_W = (RESUME_CYCLES > 1) ? $clog2(RESUME_CYCLES) : 1;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [1:0]       w_cause_nxt;
  logic [RES_W-1:0] r_res_cnt;
  logic [RES_W-1:0] w_res_cnt_nxt;
  logic             w_wake_s;
  logic             w_timer_exp;

  wake_sync #(.SYNC_STAGES(SYNC_STAGES)) u_wake_sync (
    .clk     (clk),
    .reset   (reset),
    .i_async (wakeup),
    .o_sync  (w_wake_s)
  );

`ifdef CPU_SLEEP_WAKE_TIMER_EN
  logic [TIMER_W-1:0] r_timer;

  // Reloads on the sleep request, counts down only while asleep, saturating at zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_timer <= '0;
    end else if (r_state == ST_RUN && sleep_req) begin
      r_timer <= timer_val;
    end else if (r_state == ST_SLEEP && r_timer != '0) begin
      r_timer <= TIMER_W'(r_timer - 1'b1);
    end
  end

  assign w_timer_exp = (r_state == ST_SLEEP) && (r_timer == TIMER_W'(1));
`else
  assign w_timer_exp = 1'b0;
`endif

  // Next state, wake cause and resume count; the pin takes priority over the timer.
  always_comb begin
    w_state_nxt   = r_state;
    w_cause_nxt   = wake_cause;
    w_res_cnt_nxt = '0;
    unique case (r_state)
      ST_RUN: begin
        if (sleep_req) begin
          w_state_nxt = ST_DRAIN;
          w_cause_nxt = WAKE_NONE;
        end
      end
      ST_DRAIN: begin
        if (w_wake_s) begin
          w_state_nxt = ST_RESUME;
          w_cause_nxt = WAKE_PIN;
        end else begin
          w_state_nxt = ST_SLEEP;
        end
      end
      ST_SLEEP: begin
        if (w_wake_s) begin
          w_state_nxt = ST_RESUME;
          w_cause_nxt = WAKE_PIN;
        end else if (w_timer_exp) begin
          w_state_nxt = ST_RESUME;
          w_cause_nxt = WAKE_TIMER;
        end
      end
      ST_RESUME: begin
        if (r_res_cnt == RES_W'(RESUME_CYCLES - 1)) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_res_cnt_nxt = RES_W'(r_res_cnt + 1'b1);
        end
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_RUN;
      r_res_cnt    <= '0;
      cpu_en       <= 1'b1;
      sleeping     <= 1'b0;
      wake_cause   <= WAKE_NONE;
      resume_pulse <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_res_cnt    <= w_res_cnt_nxt;
      cpu_en       <= (w_state_nxt == ST_RUN) || (w_state_nxt == ST_DRAIN);
      sleeping     <= (w_state_nxt == ST_SLEEP);
      wake_cause   <= w_cause_nxt;
      resume_pulse <= (r_state == ST_RESUME) && (w_state_nxt == ST_RUN);
    end
  end

endmodule

// File: tb/tb_cpu_sleep_ctrl.sv
// Self-checking bench for cpu_sleep_ctrl: directed and random steps against a
// cycle-level behavioural model. Timer steps only when CPU_SLEEP_WAKE_TIMER_EN is defined.
module tb_cpu_sleep_ctrl;
  import cpu_pkg::*;

  localparam int SYNC   = 2;
  localparam int RESUME = 2;

  logic       clk;
  logic       reset;
  logic       sleep_req;
  logic       wakeup;
`ifdef CPU_SLEEP_WAKE_TIMER_EN
  logic [7:0] timer_val;
`endif
  logic       cpu_en;
  logic       sleeping;
  logic [1:0] wake_cause;
  logic       resume_pulse;

  cpu_sleep_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .sleep_req    (sleep_req),
    .wakeup       (wakeup),
`ifdef CPU_SLEEP_WAKE_TIMER_EN
    .timer_val    (timer_val),
`endif
    .cpu_en       (cpu_en),
    .sleeping     (sleeping),
    .wake_cause   (wake_cause),
    .resume_pulse (resume_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model: mode, pin delay line, timer count, cycles spent resuming.
  state_t     m_mode;
  logic       m_pin_hist [SYNC];
  int         m_timer;
  int         m_res_cycles;
  logic [1:0] m_cause;
  logic       m_pulse;

  task automatic model_reset();
    m_mode = ST_RUN;
    for (int i = 0; i < SYNC; i++) m_pin_hist[i] = 1'b0;
    m_timer      = 0;
    m_res_cycles = 0;
    m_cause      = WAKE_NONE;
    m_pulse      = 1'b0;
  endtask

  task automatic model_step(input logic sr, input logic wk, input int tv);
    logic ws;
    logic expire;
    ws = m_pin_hist[SYNC-1];
    for (int i = SYNC - 1; i > 0; i--) m_pin_hist[i] = m_pin_hist[i-1];
    m_pin_hist[0] = wk;
    m_pulse = 1'b0;
    case (m_mode)
      ST_RUN: if (sr) begin
        m_mode  = ST_DRAIN;
        m_timer = tv;
        m_cause = WAKE_NONE;
      end
      ST_DRAIN: begin
        m_res_cycles = 0;
        if (ws) begin m_mode = ST_RESUME; m_cause = WAKE_PIN; end
        else m_mode = ST_SLEEP;
      end
      ST_SLEEP: begin
        expire  = (m_timer == 1);
        m_timer = (m_timer > 0) ? m_timer - 1 : 0;
        m_res_cycles = 0;
        if (ws) begin m_mode = ST_RESUME; m_cause = WAKE_PIN; end
        else if (expire) begin m_mode = ST_RESUME; m_cause = WAKE_TIMER; end
      end
      default: begin
        m_res_cycles++;
        if (m_res_cycles == RESUME) begin m_mode = ST_RUN; m_pulse = 1'b1; end
      end
    endcase
  endtask

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    logic en_exp;
    en_exp = (m_mode == ST_RUN) || (m_mode == ST_DRAIN);
    chk("cpu_en",       {1'b0, cpu_en},       {1'b0, en_exp});
    chk("sleeping",     {1'b0, sleeping},     {1'b0, m_mode == ST_SLEEP});
    chk("wake_cause",   wake_cause,           m_cause);
    chk("resume_pulse", {1'b0, resume_pulse}, {1'b0, m_pulse});
  endtask

  task automatic tick();
    logic sr;
    logic wk;
    int   tv;
    sr = sleep_req;
    wk = wakeup;
    tv = 0;
`ifdef CPU_SLEEP_WAKE_TIMER_EN
    tv = int'(timer_val);
`endif
    @(posedge clk);
    model_step(sr, wk, tv);
    #1;
    check_all();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_sleep();
    sleep_req = 1'b1;
    tick();
    sleep_req = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    sleep_req = 1'b0;
    wakeup    = 1'b0;
`ifdef CPU_SLEEP_WAKE_TIMER_EN
    timer_val = 8'd0;
`endif
    model_reset();
    #10 reset = 1'b0;
    #1 check_all();

    // Sleep with no timer: stays asleep for 300 ns.
    pulse_sleep();
    ticks(31);
    chk("held_sleep", {1'b0, sleeping}, 2'b01);

    // Pin wake for two cycles, then full resume.
    wakeup = 1'b1;
    ticks(2);
    wakeup = 1'b0;
    ticks(6);
    chk("pin_cause", wake_cause, WAKE_PIN);

`ifdef CPU_SLEEP_WAKE_TIMER_EN
    // Timer wake after 5 sleep cycles.
    timer_val = 8'd5;
    pulse_sleep();
    timer_val = 8'd0;
    ticks(12);
    chk("timer_cause", wake_cause, WAKE_TIMER);

    // Timer expiry coincides with pin wake: pin wins.
    timer_val = 8'd1;
    wakeup    = 1'b1;
    pulse_sleep();
    timer_val = 8'd0;
    ticks(6);
    wakeup = 1'b0;
    ticks(4);
    chk("tie_cause", wake_cause, WAKE_PIN);
`endif

    // Pin already high at the request: sleep aborted in DRAIN.
    wakeup = 1'b1;
    ticks(3);
    pulse_sleep();
    ticks(5);
    wakeup = 1'b0;
    ticks(4);
    chk("abort_cause", wake_cause, WAKE_PIN);

    // Sleep request on the resume-pulse cycle is honoured.
    pulse_sleep();
    ticks(2);
    wakeup = 1'b1;
    ticks(2);
    wakeup = 1'b0;
    for (int i = 0; i < 10; i++) begin
      sleep_req = m_pulse;
      tick();
    end
    sleep_req = 1'b0;
    ticks(3);

    // Asynchronous reset in the middle of SLEEP.
    wakeup = 1'b1;
    ticks(4);
    wakeup = 1'b0;
    ticks(6);
    pulse_sleep();
    ticks(4);
    #2 reset = 1'b1;
    model_reset();
    #1 check_all();
    @(posedge clk);
    #3 reset = 1'b0;
    model_reset();
    tick();

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      sleep_req = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 11) == 0) wakeup = ~wakeup;
`ifdef CPU_SLEEP_WAKE_TIMER_EN
      timer_val = 8'($urandom_range(0, 12));
`endif
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
